// File: rtl/can_bit_sampler_if.sv
// Bus between the CAN frame front-end (frame_detect/decoder side) and the bit sampler.
// master drives bus level and decoder controls; slave is the sampler.
interface can_bit_sampler_if;
  logic can_rx;
  logic sof_detect;
  logic destuff_en;
  logic frame_end;
  logic active;
  logic bit_valid;
  logic bit_data;
  logic stuff_bit;
  logic stuff_err;

  modport master (
    output can_rx, sof_detect, destuff_en, frame_end,
    input  active, bit_valid, bit_data, stuff_bit, stuff_err
  );

  modport slave (
    input  can_rx, sof_detect, destuff_en, frame_end,
    output active, bit_valid, bit_data, stuff_bit, stuff_err
  );
endinterface

// File: rtl/can_bit_sampler.sv
// CAN bit timing: hard sync on SOF, resync on recessive-to-dominant edges,
// single sample point per bit, de-stuffing and stuff/bus-idle checks.
module can_bit_sampler #(
  parameter int unsigned clk_speed_MHz      = 100,
  parameter int unsigned can_bit_rate_Kbits = 1000,
  parameter int unsigned sample_point_pct   = 75
) (
  input  logic             clk,
  input  logic             rst_n,
  can_bit_sampler_if.slave bus
);

  localparam int unsigned CLKS_PER_BIT = clk_speed_MHz * 1000 / can_bit_rate_Kbits;
  localparam int unsigned SAMPLE_CNT   = CLKS_PER_BIT * sample_point_pct / 100;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned RUN_W        = 3;
  localparam int unsigned REC_W        = 4;
  localparam int unsigned RUN_LIMIT    = 5;
  localparam int unsigned REC_LIMIT    = 11;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [REC_W-1:0]   rec_q, rec_d;
  logic [REC_W-1:0]   rec_next;
  logic               last_q, last_d;
  logic               rx_prev_q;
  logic               active_q, active_d;
  logic               bit_valid_q, bit_valid_d;
  logic               bit_data_q, bit_data_d;
  logic               stuff_bit_q, stuff_bit_d;
  logic               stuff_err_q, stuff_err_d;

  logic               fall_c;
  logic               sample_c;

  assign fall_c   = rx_prev_q & ~bus.can_rx;
  assign sample_c = (cnt_q == CNT_W'(SAMPLE_CNT));

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      run_q       <= '0;
      rec_q       <= '0;
      last_q      <= 1'b0;
      rx_prev_q   <= 1'b1;
      active_q    <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_data_q  <= 1'b0;
      stuff_bit_q <= 1'b0;
      stuff_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_q       <= run_d;
      rec_q       <= rec_d;
      last_q      <= last_d;
      rx_prev_q   <= bus.can_rx;
      active_q    <= active_d;
      bit_valid_q <= bit_valid_d;
      bit_data_q  <= bit_data_d;
      stuff_bit_q <= stuff_bit_d;
      stuff_err_q <= stuff_err_d;
    end
  end

  // Next state: bit timing, sampling, de-stuffing and frame termination
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_d       = run_q;
    rec_d       = rec_q;
    rec_next    = rec_q;
    last_d      = last_q;
    active_d    = 1'b0;
    bit_valid_d = 1'b0;
    bit_data_d  = bit_data_q;
    stuff_bit_d = 1'b0;
    stuff_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        run_d = '0;
        rec_d = '0;
        // SOF arrives one cycle after the bus edge, hence the counter starts at 2
        if (bus.sof_detect) begin
          state_d  = ACTIVE;
          cnt_d    = CNT_W'(2);
          active_d = 1'b1;
        end
      end

      ACTIVE: begin
        active_d = 1'b1;
        cnt_d    = (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) ? '0 : cnt_q + CNT_W'(1);
        if (fall_c) begin
          cnt_d = CNT_W'(1);
        end

        if (bus.frame_end) begin
          state_d = IDLE;
        end else if (sample_c) begin
          rec_next = bus.can_rx ? rec_q + REC_W'(1) : '0;
          rec_d    = rec_next;

          if (!bus.destuff_en) begin
            bit_valid_d = 1'b1;
            bit_data_d  = bus.can_rx;
            run_d       = '0;
          end else if (run_q < RUN_W'(RUN_LIMIT)) begin
            bit_valid_d = 1'b1;
            bit_data_d  = bus.can_rx;
            run_d       = (bus.can_rx == last_q) ? run_q + RUN_W'(1) : RUN_W'(1);
            last_d      = bus.can_rx;
          end else if (bus.can_rx != last_q) begin
            stuff_bit_d = 1'b1;
            run_d       = RUN_W'(1);
            last_d      = bus.can_rx;
          end else begin
            stuff_err_d = 1'b1;
            state_d     = IDLE;
          end

          // Eleven recessive samples in a row means the bus has gone idle
          if (rec_next == REC_W'(REC_LIMIT)) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.active    = active_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.bit_data  = bit_data_q;
  assign bus.stuff_bit = stuff_bit_q;
  assign bus.stuff_err = stuff_err_q;

endmodule

// File: tb/tb_can_bit_sampler.sv
// Directed bench for can_bit_sampler: expected pulses are queued with the stimulus
// and a negedge monitor pops and compares each pulse the DUT produces.
module tb_can_bit_sampler;

  localparam int KIND_VALID = 0;
  localparam int KIND_STUFF = 1;
  localparam int KIND_ERR   = 2;

  typedef struct {
    int   cyc;
    int   kind;
    logic data;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   passed;
  ev_t  exp_q[$];

  can_bit_sampler_if bus ();

  can_bit_sampler #(
    .clk_speed_MHz     (100),
    .can_bit_rate_Kbits(1000),
    .sample_point_pct  (75)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int got, input int req);
    checks++;
    if (got == req) passed++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, req, cyc);
  endfunction

  function automatic void expect_ev(input int c, input int k, input logic d);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  // Monitor: every pulse must match the head of the scoreboard queue
  int   mon_kind;
  int   mon_cnt;
  ev_t  mon_e;
  always @(negedge clk) begin
    if (rst_n && (bus.bit_valid || bus.stuff_bit || bus.stuff_err)) begin
      mon_cnt  = int'(bus.bit_valid) + int'(bus.stuff_bit) + int'(bus.stuff_err);
      mon_kind = bus.bit_valid ? KIND_VALID : (bus.stuff_bit ? KIND_STUFF : KIND_ERR);
      check("single_pulse", mon_cnt, 1);
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, required no pulse", mon_kind, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_cycle", cyc, mon_e.cyc);
        check("pulse_kind", mon_kind, mon_e.kind);
        if (mon_e.kind == KIND_VALID) check("bit_data", int'(bus.bit_data), int'(mon_e.data));
      end
    end
  end

  task automatic tick(input logic rx, input logic sof, input logic den, input logic fe);
    @(posedge clk);
    #1;
    bus.can_rx     = rx;
    bus.sof_detect = sof;
    bus.destuff_en = den;
    bus.frame_end  = fe;
  endtask

  // Drives a frame whose SOF edge is at cycle t-1 (t = cyc+2 at call time).
  // All *_at arguments are offsets from t; -1 disables.
  task automatic send_frame(input logic [15:0] bits, input int nbits, input logic den,
                            input int late_bit, input int late, input int fe_at,
                            input int a1_at, input int a0_at);
    int rel;
    int dur;
    rel = 0;
    for (int k = 0; k < nbits; k++) begin
      dur = 100 + ((k == late_bit - 1) ? late : 0);
      for (int j = 0; j < dur; j++) begin
        tick(bits[k], rel == 1, den, (fe_at >= 0) && (rel == fe_at + 1));
        if (rel == 1) check("active_before_sof", int'(bus.active), 0);
        if (rel == 2) check("active_after_sof", int'(bus.active), 1);
        if (a1_at >= 0 && rel == a1_at + 1) check("active_high", int'(bus.active), 1);
        if (a0_at >= 0 && rel == a0_at + 1) check("active_low", int'(bus.active), 0);
        rel++;
      end
    end
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (150) tick(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int         t;
    logic [15:0] b;
    checks = 0;
    passed = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    bus.can_rx     = 1'b1;
    bus.sof_detect = 1'b0;
    bus.destuff_en = 1'b0;
    bus.frame_end  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_active", int'(bus.active), 0);
    check("reset_bit_valid", int'(bus.bit_valid), 0);
    check("reset_bit_data", int'(bus.bit_data), 0);
    check("reset_stuff_bit", int'(bus.stuff_bit), 0);
    check("reset_stuff_err", int'(bus.stuff_err), 0);
    rst_n = 1'b1;
    repeat (20) tick(1'b1, 1'b0, 1'b0, 1'b0);

    // Basic sampling: 0 1 0 1 1, no de-stuffing
    b = 16'd26;
    t = cyc + 2;
    for (int k = 0; k < 5; k++) expect_ev(t + 75 + 100 * k, KIND_VALID, b[k]);
    send_frame(b, 5, 1'b0, -1, 0, -1, 474, -1);

    // Resync: bit 3 edge 7 clocks late shifts that and all later samples
    b = 16'd86;
    t = cyc + 2;
    for (int k = 0; k < 7; k++) expect_ev(t + 75 + 100 * k + ((k >= 3) ? 7 : 0), KIND_VALID, b[k]);
    send_frame(b, 7, 1'b0, 3, 7, -1, -1, -1);

    // De-stuffing: five 0s, stuff 1, five 0s (run restarted at 1), stuff 1, 0
    b = 16'd2080;
    t = cyc + 2;
    for (int k = 0; k < 13; k++)
      expect_ev(t + 75 + 100 * k, (k == 5 || k == 11) ? KIND_STUFF : KIND_VALID, 1'b0);
    send_frame(b, 13, 1'b1, -1, 0, -1, -1, -1);

    // Stuff error: sixth consecutive 0
    b = 16'd0;
    t = cyc + 2;
    for (int k = 0; k < 5; k++) expect_ev(t + 75 + 100 * k, KIND_VALID, 1'b0);
    expect_ev(t + 575, KIND_ERR, 1'b0);
    send_frame(b, 6, 1'b1, -1, 0, -1, 575, 576);

    // frame_end coincident with the bit-2 sample cycle suppresses that sample
    b = 16'd26;
    t = cyc + 2;
    expect_ev(t + 75, KIND_VALID, 1'b0);
    expect_ev(t + 175, KIND_VALID, 1'b1);
    send_frame(b, 6, 1'b0, -1, 0, 274, 274, 276);

    // Bus-idle guard: SOF then eleven recessive samples
    b = 16'd4094;
    t = cyc + 2;
    expect_ev(t + 75, KIND_VALID, 1'b0);
    for (int k = 1; k < 12; k++) expect_ev(t + 75 + 100 * k, KIND_VALID, 1'b1);
    send_frame(b, 12, 1'b0, -1, 0, -1, 1175, 1176);

    // Reset mid-frame while bit_valid/bit_data are high
    t = cyc + 2;
    expect_ev(t + 75, KIND_VALID, 1'b0);
    expect_ev(t + 175, KIND_VALID, 1'b1);
    for (int rel = 0; rel <= 176; rel++)
      tick((rel >= 100 && rel < 200) ? 1'b1 : 1'b0, rel == 1, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    check("bit_valid_before_reset", int'(bus.bit_valid), 1);
    rst_n = 1'b0;
    #1;
    check("rst_active", int'(bus.active), 0);
    check("rst_bit_valid", int'(bus.bit_valid), 0);
    check("rst_bit_data", int'(bus.bit_data), 0);
    check("rst_stuff_bit", int'(bus.stuff_bit), 0);
    check("rst_stuff_err", int'(bus.stuff_err), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick(((i / 50) % 2) == 1, 1'b0, 1'b0, 1'b0);
      if (i == 100 || i == 399) check("active_after_reset", int'(bus.active), 0);
    end

    repeat (5) tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("scoreboard_drained", exp_q.size(), 0);
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      $display("FAIL missing_pulse: got none, required kind %0d at cycle %0d", mon_e.kind, mon_e.cyc);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
